mem_arbiter: RTL and testbench

- Shares the single external memory port between two requesters: the CPU bus interface (read/write/busmem path) and the front-panel loader used in the load/inspect cpustates.
- Two-way round-robin arbitration with a wait-state counter sized to memory latency.
- Per-requester req/ack handshake and a registered read-data return.
- Sits between the CPU top level and the memory/panel logic.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_rr_arb2.sv | 14 +
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-way memory arbiter.
// The arbiter, its round-robin picker and the bus interface all import this package.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_PNL = 1'b1;

  // Width of the wait-state counter; at least one bit even when WAIT_CYC is 0.
  function automatic int cnt_width(input int wait_cyc);
    return (wait_cyc > 0) ? $clog2(wait_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter, bundled into one interface.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          pnl_req;
  logic          pnl_we;
  logic [AW-1:0] pnl_addr;
  logic [DW-1:0] pnl_wdata;
  logic          pnl_ack;
  logic [DW-1:0] pnl_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read;
  logic          mem_write;

  logic          busy;
  logic          grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  pnl_req, pnl_we, pnl_addr, pnl_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, pnl_ack, pnl_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    output busy, grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output pnl_req, pnl_we, pnl_addr, pnl_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, pnl_ack, pnl_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    input  busy, grant
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the one that
// did not own the previous access wins. The last-owner register lives in the parent.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  assign valid = req0 | req1;
  assign pick  = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between the CPU bus and the front-panel loader.
// Each access runs IDLE (arbitrate) -> ACCESS (WAIT_CYC+1 cycles) -> DONE (ack pulse).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int            CW       = cnt_width(WAIT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          owner;      // grant and last-owner are always the same value
  logic          we_lat;
  logic [AW-1:0] addr_lat;
  logic [DW-1:0] wdata_lat;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] pnl_rdata_r;

  logic          pick_valid;
  logic          pick;
  logic          last_cycle;

  logic          mem_read_c;
  logic          mem_write_c;
  logic          cpu_ack_c;
  logic          pnl_ack_c;
  logic          busy_c;

  rr_arb2 u_rr_arb2 (
    .req0  (bus.cpu_req),
    .req1  (bus.pnl_req),
    .last  (owner),
    .valid (pick_valid),
    .pick  (pick)
  );

  assign last_cycle = (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: defaulting every always_comb output first keeps all paths assigned,
  // so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nx = ACCESS;
      ACCESS:  if (last_cycle) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and acks decode straight from state, so an asynchronous reset
  // drops them at once without waiting for a clock edge.
  always_comb begin
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    cpu_ack_c   = 1'b0;
    pnl_ack_c   = 1'b0;
    busy_c      = 1'b0;
    unique case (state)
      ACCESS: begin
        mem_read_c  = ~we_lat;
        mem_write_c = we_lat;
        busy_c      = 1'b1;
      end
      DONE: begin
        cpu_ack_c = (owner == GNT_CPU);
        pnl_ack_c = (owner == GNT_PNL);
        busy_c    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the read-data holding registers are ordinary flops and get an
  // explicit reset value; they are not memory arrays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      owner       <= GNT_PNL;
      we_lat      <= 1'b0;
      addr_lat    <= '0;
      wdata_lat   <= '0;
      cpu_rdata_r <= '0;
      pnl_rdata_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            cnt   <= '0;
            if (pick == GNT_PNL) begin
              we_lat    <= bus.pnl_we;
              addr_lat  <= bus.pnl_addr;
              wdata_lat <= bus.pnl_wdata;
            end else begin
              we_lat    <= bus.cpu_we;
              addr_lat  <= bus.cpu_addr;
              wdata_lat <= bus.cpu_wdata;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last_cycle && !we_lat) begin
            if (owner == GNT_PNL) pnl_rdata_r <= bus.mem_rdata;
            else                  cpu_rdata_r <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = addr_lat;
  assign bus.mem_wdata = wdata_lat;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.cpu_ack   = cpu_ack_c;
  assign bus.pnl_ack   = pnl_ack_c;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.pnl_rdata = pnl_rdata_r;
  assign bus.busy      = busy_c;
  assign bus.grant     = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues the expected access,
// a monitor checks each completed access when its ack pulses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Memory returns a fixed function of the address: 16'h0010 -> 8'hA5.
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction

  assign bus.mem_rdata  = mem_fn(bus.mem_addr);
  assign bus0.mem_rdata = mem_fn(bus0.mem_addr);

  typedef struct {
    logic        who;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  cpu_rd;
    logic [7:0]  pnl_rd;
  } exp_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_cpu_rd = '0;
  logic [7:0] m_pnl_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_access(input logic who, input logic we,
                               input logic [15:0] addr, input logic [7:0] wdata);
    exp_t e;
    if (!we) begin
      if (who == GNT_CPU) m_cpu_rd = mem_fn(addr);
      else                m_pnl_rd = mem_fn(addr);
    end
    e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    e.cpu_rd = m_cpu_rd; e.pnl_rd = m_pnl_rd;
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input logic who, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (who == GNT_CPU) ? bus.cpu_ack : bus.pnl_ack;
    end
    if (!got) check(name, got, 1);
  endtask

  // Monitor: collects strobe activity per access and compares on the ack.
  int          strobe_n;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_we;
  logic        s_bad;
  logic        after_ack;

  always @(negedge clk) begin
    if (rst) begin
      strobe_n  = 0;
      s_bad     = 1'b0;
      after_ack = 1'b0;
    end else begin
      if (after_ack) begin
        check("idle_gap_after_ack", {bus.busy, bus.cpu_ack, bus.pnl_ack}, 3'b000);
        after_ack = 1'b0;
      end
      if (bus.mem_read || bus.mem_write) begin
        if (strobe_n == 0) begin
          s_addr  = bus.mem_addr;
          s_wdata = bus.mem_wdata;
          s_we    = bus.mem_write;
          s_bad   = bus.mem_read && bus.mem_write;
        end else if (bus.mem_addr !== s_addr || bus.mem_wdata !== s_wdata ||
                     bus.mem_write !== s_we || (bus.mem_read && bus.mem_write)) begin
          s_bad = 1'b1;
        end
        strobe_n++;
      end
      if (bus.cpu_ack || bus.pnl_ack) begin
        if (sbq.size() == 0) begin
          check("ack_with_empty_scoreboard", sbq.size(), 1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("ack_owner", {bus.cpu_ack, bus.pnl_ack}, (e.who == GNT_CPU) ? 2'b10 : 2'b01);
          check("grant", bus.grant, e.who);
          check("mem_addr", s_addr, e.addr);
          check("mem_write_vs_read", s_we, e.we);
          if (e.we) check("mem_wdata", s_wdata, e.wdata);
          check("strobe_cycles", strobe_n, 2);
          check("strobe_stable_exclusive", s_bad, 1'b0);
          check("cpu_rdata", bus.cpu_rdata, e.cpu_rd);
          check("pnl_rdata", bus.pnl_rdata, e.pnl_rd);
        end
        strobe_n  = 0;
        s_bad     = 1'b0;
        after_ack = 1'b1;
      end
    end
  end

  initial begin
    int n_acks;
    int n_busy;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.pnl_req = 0; bus.pnl_we = 0; bus.pnl_addr = '0; bus.pnl_wdata = '0;
    bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.pnl_req = 0; bus0.pnl_we = 0; bus0.pnl_addr = '0; bus0.pnl_wdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_strobes_acks_busy",
          {bus.mem_read, bus.mem_write, bus.cpu_ack, bus.pnl_ack, bus.busy}, 5'b0);
    check("rst_grant", bus.grant, 1'b1);
    check("rst_rdata", {bus.cpu_rdata, bus.pnl_rdata}, 16'h0);
    check("rst_mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 24'h0);
    rst = 1'b0;
    @(negedge clk);

    // CPU read alone, with cycle-exact latency
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
    expect_access(GNT_CPU, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    check("t1_c1_mem_read", {bus.mem_read, bus.mem_write}, 2'b10);
    check("t1_c1_mem_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    check("t1_c2_mem_read", {bus.mem_read, bus.cpu_ack}, 2'b10);
    @(negedge clk);
    check("t1_c3_acks", {bus.cpu_ack, bus.pnl_ack, bus.mem_read}, 3'b100);
    check("t1_c3_rdata", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 0;
    @(negedge clk);

    // Panel write
    bus.pnl_req = 1; bus.pnl_we = 1; bus.pnl_addr = 16'h1234; bus.pnl_wdata = 8'h3C;
    expect_access(GNT_PNL, 1'b1, 16'h1234, 8'h3C);
    wait_ack(GNT_PNL, "t2_pnl_ack_timeout");
    bus.pnl_req = 0; bus.pnl_we = 0;
    @(negedge clk);

    // CPU request dropped and address changed mid-ACCESS
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0020;
    expect_access(GNT_CPU, 1'b0, 16'h0020, 8'h00);
    @(negedge clk);
    bus.cpu_req = 0; bus.cpu_addr = 16'h0099;
    wait_ack(GNT_CPU, "t6_cpu_ack_timeout");
    n_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy) n_busy++;
    end
    check("t6_no_second_access", n_busy, 0);

    // Reset in the middle of a write
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0055; bus.cpu_wdata = 8'h77;
    @(negedge clk);
    check("t5_write_active", {bus.mem_write, bus.busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("t5_async_drop", {bus.mem_write, bus.mem_read, bus.busy, bus.cpu_ack, bus.pnl_ack}, 5'b0);
    check("t5_async_grant", bus.grant, 1'b1);
    check("t5_async_mem_addr", bus.mem_addr, 16'h0);
    @(negedge clk);
    m_cpu_rd = '0; m_pnl_rd = '0;

    // Both held from reset: CPU, panel, CPU, panel
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0030;
    bus.pnl_req = 1; bus.pnl_we = 0; bus.pnl_addr = 16'h0041;
    expect_access(GNT_CPU, 1'b0, 16'h0030, 8'h00);
    expect_access(GNT_PNL, 1'b0, 16'h0041, 8'h00);
    expect_access(GNT_CPU, 1'b0, 16'h0030, 8'h00);
    expect_access(GNT_PNL, 1'b0, 16'h0041, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    n_acks = 0;
    for (int i = 0; i < 40 && n_acks < 4; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.pnl_ack) n_acks++;
    end
    bus.cpu_req = 0; bus.pnl_req = 0;
    check("t3_four_acks", n_acks, 4);
    repeat (3) @(negedge clk);

    // WAIT_CYC=0 build, CPU read
    bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 16'h0010;
    @(negedge clk);
    check("w0_c1", {bus0.mem_read, bus0.cpu_ack}, 2'b10);
    @(negedge clk);
    check("w0_c2", {bus0.mem_read, bus0.cpu_ack}, 2'b01);
    check("w0_rdata", bus0.cpu_rdata, 8'hA5);
    bus0.cpu_req = 0;
    @(negedge clk);
    check("w0_idle", bus0.busy, 1'b0);

    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
